noc_packetizer: RTL and testbench

//  Clocked network interface on the injection side of one 3x5 mesh node. It takes
//  {dest, 40b payload} from the local PE and precomputes the XY route header
//  (dir/hop per axis). It buffers packets in a small FIFO and presents 57-bit

---
 rtl/noc_packetizer_pkg.sv | 61 ++++++
 rtl/noc_packetizer_if.sv | 16 +
 rtl/noc_packetizer_sync_fifo.sv | 63 ++++++
 rtl/noc_packetizer.sv | 63 ++++++
 tb/tb_noc_packetizer.sv | 212 +++++++++++++++++++++
 5 files changed

// File: rtl/noc_packetizer_pkg.sv
// noc_packetizer_pkg: packet layout, mesh geometry and XY route header helpers
package noc_packetizer_pkg;

    localparam int NUM_NODES = 15;
    localparam int MESH_COLS = 5;
    localparam int NODE_W    = 4;
    localparam int HOP_W     = 3;
    localparam int PAYLOAD_W = 40;
    localparam int NOC_PKT_W = 57;

    localparam int PAYLOAD_LSB = 0;
    localparam int YHOP_LSB    = 40;
    localparam int YDIR_BIT    = 43;
    localparam int XHOP_LSB    = 44;
    localparam int XDIR_BIT    = 47;
    localparam int DEST_LSB    = 48;
    localparam int SRC_LSB     = 52;
    localparam int RSVD_BIT    = 56;

    typedef struct packed {
        logic             xdir;
        logic [HOP_W-1:0] xhop;
        logic             ydir;
        logic [HOP_W-1:0] yhop;
    } route_hdr_t;

    typedef struct packed {
        logic                 rsvd;
        logic [NODE_W-1:0]    src;
        logic [NODE_W-1:0]    dest;
        route_hdr_t           route;
        logic [PAYLOAD_W-1:0] payload;
    } noc_pkt_t;

    typedef enum logic [1:0] {FIFO_EMPTY, FIFO_PARTIAL, FIFO_FULL} fifo_state_t;

    // Physical rows are not in id order: ids 5-9 sit on row 0, 0-4 on row 1, 10-14 on row 2
    function automatic logic [1:0] node_row(input logic [NODE_W-1:0] id);
        return id < 4'd5 ? 2'd1 : id < 4'd10 ? 2'd0 : 2'd2;
    endfunction

    function automatic logic [2:0] node_col(input logic [NODE_W-1:0] id);
        return 3'(id % 4'd5);
    endfunction

    function automatic route_hdr_t route_hdr(input logic [NODE_W-1:0] src, input logic [NODE_W-1:0] dst);
        logic [2:0] cs, cd;
        logic [1:0] ys, yd;
        route_hdr_t h;
        cs = node_col(src);
        cd = node_col(dst);
        ys = node_row(src);
        yd = node_row(dst);
        h.xdir = cd > cs;
        h.xhop = cd > cs ? cd - cs : cs - cd;
        h.ydir = yd > ys;
        h.yhop = yd > ys ? {1'b0, yd - ys} : {1'b0, ys - yd};
        return h;
    endfunction

endpackage

// File: rtl/noc_packetizer_if.sv
// noc_packetizer_if: PE request and router inject handshakes of the packetizer
interface noc_packetizer_if;
    import noc_packetizer_pkg::*;

    logic                 pe_valid;
    logic                 pe_ready;
    logic [NODE_W-1:0]    pe_dest;
    logic [PAYLOAD_W-1:0] pe_data;
    logic                 pkt_valid;
    logic                 pkt_ready;
    logic [NOC_PKT_W-1:0] pkt_data;

    modport master (output pe_valid, pe_dest, pe_data, pkt_ready, input pe_ready, pkt_valid, pkt_data);
    modport slave  (input pe_valid, pe_dest, pe_data, pkt_ready, output pe_ready, pkt_valid, pkt_data);

endinterface

// File: rtl/noc_packetizer_sync_fifo.sv
// noc_sync_fifo: registered-write synchronous FIFO, head visible combinationally
module noc_sync_fifo
    import noc_packetizer_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   push,
    input  logic                   pop,
    input  logic [WIDTH-1:0]       din,
    output logic [WIDTH-1:0]       dout,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] count
);

    localparam int AW = $clog2(DEPTH);

    if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
        $error("noc_sync_fifo: DEPTH must be a power of 2 and >= 2");
    end

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr, rd_ptr;
    logic             do_push, do_pop;
    fifo_state_t      state;

    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign dout    = mem[rd_ptr];
    assign full    = state == FIFO_FULL;
    assign empty   = state == FIFO_EMPTY;

    // Occupancy class derived from the count; there is no separate state register
    always_comb begin
        state = count == '0 ? FIFO_EMPTY : count == (AW+1)'(DEPTH) ? FIFO_FULL : FIFO_PARTIAL;
    end

    // Storage is cleared on reset so the head reads zero while the FIFO is empty
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else if (do_push) begin
            mem[wr_ptr] <= din;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of 2
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop) rd_ptr <= rd_ptr + 1'b1;
            count <= count + (AW+1)'(do_push) - (AW+1)'(do_pop);
        end
    end

endmodule

// File: rtl/noc_packetizer.sv
// noc_packetizer: builds XY-routed packets from PE requests and queues them for injection
module noc_packetizer
    import noc_packetizer_pkg::*;
#(
    parameter int NODE_ID = 0,
    parameter int DEPTH   = 4,
    parameter int PKT_W   = 57
) (
    input  logic                   clk,
    input  logic                   rst_n,
    noc_packetizer_if.slave        bus,
    output logic [$clog2(DEPTH):0] fifo_count,
    output logic                   drop_pulse,
    output logic [15:0]            drop_cnt
);

    if (NODE_ID < 0 || NODE_ID >= NUM_NODES) begin : g_bad_node
        $error("noc_packetizer: NODE_ID must be 0..14");
    end
    if (PKT_W != NOC_PKT_W) begin : g_bad_width
        $error("noc_packetizer: PKT_W must match the packet layout");
    end

    localparam logic [NODE_W-1:0] SRC = NODE_W'(NODE_ID);

    logic     full, empty, accept, drop, push;
    noc_pkt_t pkt_in;

    assign accept        = bus.pe_valid && bus.pe_ready;
    assign drop          = bus.pe_dest >= NODE_W'(NUM_NODES) || bus.pe_dest == SRC;
    assign push          = accept && !drop;
    assign bus.pe_ready  = !full;
    assign bus.pkt_valid = !empty;

    // Route header is computed at the PE side so the FIFO holds finished packets
    always_comb begin
        pkt_in = '{rsvd: 1'b0, src: SRC, dest: bus.pe_dest, route: route_hdr(SRC, bus.pe_dest), payload: bus.pe_data};
    end

    noc_sync_fifo #(.WIDTH(NOC_PKT_W), .DEPTH(DEPTH)) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (push),
        .pop   (bus.pkt_valid && bus.pkt_ready),
        .din   (pkt_in),
        .dout  (bus.pkt_data),
        .full  (full),
        .empty (empty),
        .count (fifo_count)
    );

    // Dropped requests still complete the handshake; flag them and count with saturation
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            drop_pulse <= 1'b0;
            drop_cnt   <= '0;
        end else begin
            drop_pulse <= accept && drop;
            if (accept && drop && drop_cnt != 16'hFFFF) drop_cnt <= drop_cnt + 16'd1;
        end
    end

endmodule

// File: tb/tb_noc_packetizer.sv
// tb_noc_packetizer: vectors, backpressure/drop/reset sequences and a random stream vs a queue model
module tb_noc_packetizer;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [2:0]  cnt0, cnt13;
    logic        dp0, dp13;
    logic [15:0] dc0, dc13;
    int          tests = 0;
    int          fails = 0;

    noc_packetizer_if b0();
    noc_packetizer_if b13();

    noc_packetizer #(.NODE_ID(0), .DEPTH(4), .PKT_W(57)) u0 (
        .clk(clk), .rst_n(rst_n), .bus(b0), .fifo_count(cnt0), .drop_pulse(dp0), .drop_cnt(dc0)
    );
    noc_packetizer #(.NODE_ID(13), .DEPTH(4), .PKT_W(57)) u13 (
        .clk(clk), .rst_n(rst_n), .bus(b13), .fifo_count(cnt13), .drop_pulse(dp13), .drop_cnt(dc13)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          node;
        logic [3:0]  dest;
        logic [39:0] data;
        logic [56:0] exp;
    } vec_t;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Reference packet from mesh coordinates: column = id mod 5, rows per id group {1,0,2}
    function automatic logic [56:0] model_pkt(input int s, input int d, input logic [39:0] p);
        int row [3];
        int xs, xd, ys, yd, xh, yh;
        row = '{1, 0, 2};
        xs = s % 5;
        xd = d % 5;
        ys = row[s / 5];
        yd = row[d / 5];
        xh = xd > xs ? xd - xs : xs - xd;
        yh = yd > ys ? yd - ys : ys - yd;
        return (57'(s) << 52) | (57'(d) << 48) | (57'(xd > xs) << 47) | (57'(xh) << 44)
             | (57'(yd > ys) << 43) | (57'(yh) << 40) | 57'(p);
    endfunction

    vec_t        vec [7];
    logic [56:0] q [$];
    logic [56:0] held;
    logic [39:0] rdata;
    logic [3:0]  rdest;
    logic        acc, stalled, exp_pulse;
    int          legal_acc, exp_drops, cyc;

    initial begin
        vec[0] = '{0,  4'd7,  40'h12,         57'h07A10000000012};
        vec[1] = '{13, 4'd6,  40'hABCDE,      57'hD62200000ABCDE};
        vec[2] = '{13, 4'd11, 40'h5,          57'hDB200000000005};
        vec[3] = '{0,  4'd14, 40'hFFFFFFFFFF, 57'h0EC9FFFFFFFFFF};
        vec[4] = '{13, 4'd0,  40'h0123456789, 57'hD0310123456789};
        vec[5] = '{0,  4'd5,  40'h0,          57'h05010000000000};
        vec[6] = '{13, 4'd14, 40'h1,          57'hDE900000000001};

        b0.pe_valid = 0;  b0.pe_dest = 0;  b0.pe_data = 0;  b0.pkt_ready = 1;
        b13.pe_valid = 0; b13.pe_dest = 0; b13.pe_data = 0; b13.pkt_ready = 1;

        repeat (2) @(negedge clk);
        chk("rst_pkt_valid", b0.pkt_valid, 0);
        chk("rst_fifo_count", cnt0, 0);
        chk("rst_pkt_data", b0.pkt_data, 0);
        chk("rst_drop_pulse", dp0, 0);
        chk("rst_drop_cnt", dc0, 0);
        rst_n = 1;
        @(negedge clk);
        chk("rst_pe_ready", b0.pe_ready, 1);

        for (int i = 0; i < 7; i++) begin
            @(negedge clk);
            if (vec[i].node == 0) begin
                b0.pe_valid = 1; b0.pe_dest = vec[i].dest; b0.pe_data = vec[i].data;
            end else begin
                b13.pe_valid = 1; b13.pe_dest = vec[i].dest; b13.pe_data = vec[i].data;
            end
            @(posedge clk); #1;
            b0.pe_valid = 0;
            b13.pe_valid = 0;
            chk("vec_valid", vec[i].node == 0 ? b0.pkt_valid : b13.pkt_valid, 1);
            chk("vec_pkt", vec[i].node == 0 ? b0.pkt_data : b13.pkt_data, vec[i].exp);
        end
        repeat (2) @(posedge clk);
        #1 chk("vec_drained", b0.pkt_valid | b13.pkt_valid, 0);

        b0.pkt_ready = 0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("bp_pe_ready", b0.pe_ready, i < 4);
            b0.pe_valid = 1; b0.pe_dest = 4'(i + 1); b0.pe_data = 40'(i);
            @(posedge clk); #1;
            if (i < 4) b0.pe_valid = 0;
        end
        chk("bp_count_full", cnt0, 4);
        chk("bp_pe_ready_full", b0.pe_ready, 0);
        chk("bp_valid_full", b0.pkt_valid, 1);
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            b0.pkt_ready = 1;
            chk("bp_order", b0.pkt_data, model_pkt(0, k + 1, 40'(k)));
            if (k < 2) chk("bp_pe_ready_drain", b0.pe_ready, k == 1);
            @(posedge clk); #1;
            if (k == 1) b0.pe_valid = 0;
        end
        chk("bp_count_empty", cnt0, 0);
        chk("bp_valid_empty", b0.pkt_valid, 0);

        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            chk("drop_pe_ready", b0.pe_ready, 1);
            b0.pe_valid = 1; b0.pe_dest = i == 0 ? 4'd0 : 4'd15; b0.pe_data = 40'hDEAD;
            @(posedge clk); #1;
            b0.pe_valid = 0;
            chk("drop_pulse", dp0, 1);
            chk("drop_no_pkt", b0.pkt_valid, 0);
            chk("drop_cnt_step", dc0, i + 1);
        end
        @(posedge clk); #1;
        chk("drop_pulse_clear", dp0, 0);
        chk("drop_cnt", dc0, 2);

        exp_drops = 2;
        legal_acc = 0;
        cyc = 0;
        stalled = 0;
        exp_pulse = 0;
        held = '0;
        while ((legal_acc < 200 || q.size() != 0) && cyc < 20000) begin
            @(negedge clk);
            cyc++;
            chk("rnd_count", cnt0, q.size());
            chk("rnd_valid", b0.pkt_valid, q.size() != 0);
            chk("rnd_pe_ready", b0.pe_ready, q.size() < 4);
            if (q.size() != 0) chk("rnd_data", b0.pkt_data, q[0]);
            if (stalled) chk("rnd_hold", b0.pkt_data, held);
            chk("rnd_drop_pulse", dp0, exp_pulse);
            if (!b0.pe_valid && legal_acc < 200 && $urandom_range(0, 3) != 0) begin
                rdest = 4'($urandom_range(0, 15));
                rdata = {8'($urandom()), $urandom()};
                b0.pe_valid = 1; b0.pe_dest = rdest; b0.pe_data = rdata;
            end
            b0.pkt_ready = 1'($urandom_range(0, 1));
            acc = b0.pe_valid && q.size() < 4;
            stalled = q.size() != 0 && !b0.pkt_ready;
            held = b0.pkt_data;
            exp_pulse = acc && (b0.pe_dest == 0 || b0.pe_dest == 15);
            if (q.size() != 0 && b0.pkt_ready) void'(q.pop_front());
            if (acc) begin
                if (exp_pulse) exp_drops++;
                else begin
                    q.push_back(model_pkt(0, int'(b0.pe_dest), b0.pe_data));
                    legal_acc++;
                end
            end
            @(posedge clk); #1;
            if (acc) b0.pe_valid = 0;
        end
        if (cyc >= 20000) begin
            tests++;
            fails++;
            $display("FAIL rnd_timeout: got %0d legal packets, expected 200 within budget", legal_acc);
        end
        @(negedge clk);
        chk("rnd_last_pulse", dp0, exp_pulse);
        chk("rnd_drop_cnt", dc0, exp_drops);

        b0.pkt_ready = 0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            b0.pe_valid = 1; b0.pe_dest = 4'd3; b0.pe_data = 40'(i);
            @(posedge clk); #1;
            b0.pe_valid = 0;
        end
        chk("mid_count", cnt0, 3);
        @(negedge clk);
        #2 rst_n = 0;
        #1;
        chk("mid_rst_valid", b0.pkt_valid, 0);
        chk("mid_rst_count", cnt0, 0);
        chk("mid_rst_data", b0.pkt_data, 0);
        chk("mid_rst_drop_cnt", dc0, 0);
        @(negedge clk);
        rst_n = 1;
        b0.pkt_ready = 1;
        @(negedge clk);
        b0.pe_valid = 1; b0.pe_dest = 4'd7; b0.pe_data = 40'h12;
        @(posedge clk); #1;
        b0.pe_valid = 0;
        chk("post_rst_pkt", b0.pkt_data, 57'h07A10000000012);
        chk("post_rst_count", cnt0, 1);
        @(posedge clk); #1;
        chk("post_rst_drained", b0.pkt_valid, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
